vga_timing_ctrl: RTL and testbench

Sequences the horizontal and vertical counting for the VGA controller. Two coupled per-axis state machines (active, front porch, sync, back porch) each use one phase counter. From these it produces hsync, vsync, data-enable, pixel coordinates, and line/frame strobes for the pixel pipeline. It advances only on the pixel-clock enable derived from the system clock.

---
 rtl/vga_timing_ctrl.sv | 152 +++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: coupled horizontal/vertical phase machines that produce
// sync levels, data enable, pixel coordinates and line/frame strobes.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_end,
  output logic          frame_start
);

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } axis_state_t;

  localparam logic [CW-1:0] H_ACT_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] H_FP_LAST   = CW'(H_FP - 1);
  localparam logic [CW-1:0] H_SYNC_LAST = CW'(H_SYNC - 1);
  localparam logic [CW-1:0] H_BP_LAST   = CW'(H_BP - 1);
  localparam logic [CW-1:0] V_ACT_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] V_FP_LAST   = CW'(V_FP - 1);
  localparam logic [CW-1:0] V_SYNC_LAST = CW'(V_SYNC - 1);
  localparam logic [CW-1:0] V_BP_LAST   = CW'(V_BP - 1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // A zero-length phase would make the machines skip a state; refuse it up front.
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_len
    $error("vga_timing_ctrl: every active/porch/sync length must be at least 1");
  end

  axis_state_t   h_state, h_state_nx;
  axis_state_t   v_state, v_state_nx;
  logic [CW-1:0] h_phase, h_phase_nx;
  logic [CW-1:0] v_phase, v_phase_nx;
  logic [CW-1:0] h_end, v_end;
  logic          h_at_end, v_at_end;
  logic          line_wrap, frame_wrap;

  function automatic axis_state_t succ(input axis_state_t s);
    case (s)
      ACT:     succ = FP;
      FP:      succ = SYNC;
      SYNC:    succ = BP;
      default: succ = ACT;
    endcase
  endfunction

  always_comb begin
    h_end = H_ACT_LAST;
    case (h_state)
      FP:      h_end = H_FP_LAST;
      SYNC:    h_end = H_SYNC_LAST;
      BP:      h_end = H_BP_LAST;
      default: h_end = H_ACT_LAST;
    endcase
    h_at_end   = (h_phase == h_end);
    h_state_nx = h_state;
    h_phase_nx = h_phase;
    if (pix_en) begin
      if (h_at_end) begin
        h_state_nx = succ(h_state);
        h_phase_nx = '0;
      end else begin
        h_phase_nx = h_phase + CW'(1);
      end
    end
  end

  assign line_wrap = pix_en && (h_state == BP) && h_at_end;

  // The vertical machine counts lines, so it only moves on the line wrap.
  always_comb begin
    v_end = V_ACT_LAST;
    case (v_state)
      FP:      v_end = V_FP_LAST;
      SYNC:    v_end = V_SYNC_LAST;
      BP:      v_end = V_BP_LAST;
      default: v_end = V_ACT_LAST;
    endcase
    v_at_end   = (v_phase == v_end);
    v_state_nx = v_state;
    v_phase_nx = v_phase;
    if (line_wrap) begin
      if (v_at_end) begin
        v_state_nx = succ(v_state);
        v_phase_nx = '0;
      end else begin
        v_phase_nx = v_phase + CW'(1);
      end
    end
  end

  assign frame_wrap = line_wrap && (v_state == BP) && v_at_end;

  // Outputs are decoded from the next state so they line up with the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_state     <= ACT;
      v_state     <= ACT;
      h_phase     <= '0;
      v_phase     <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      de          <= 1'b1;
      x           <= '0;
      y           <= '0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_state     <= h_state_nx;
      v_state     <= v_state_nx;
      h_phase     <= h_phase_nx;
      v_phase     <= v_phase_nx;
      hsync       <= (h_state_nx == SYNC) ? HS_ON : ~HS_ON;
      vsync       <= (v_state_nx == SYNC) ? VS_ON : ~VS_ON;
      de          <= (h_state_nx == ACT) && (v_state_nx == ACT);
      x           <= (h_state_nx == ACT) ? h_phase_nx : '0;
      y           <= (v_state_nx == ACT) ? v_phase_nx : '0;
      line_end    <= line_wrap;
      frame_start <= frame_wrap;
    end
  end

  a_h_phase_bound: assert property (@(posedge clk) disable iff (rst) h_phase <= h_end);
  a_v_phase_bound: assert property (@(posedge clk) disable iff (rst) v_phase <= v_end);
  a_hold_when_idle: assert property (@(posedge clk) disable iff (rst)
    !pix_en |=> $stable({h_state, h_phase, v_state, v_phase}));
  a_line_end_pulse: assert property (@(posedge clk) disable iff (rst) line_end |=> !line_end);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a position-counter model predicts every output of three
// instances (default, small, small with inverted sync polarity) each clock.
module tb_vga_timing_ctrl;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;

  logic          def_hsync, def_vsync, def_de, def_le, def_fs;
  logic [CW-1:0] def_x, def_y;
  logic          sm_hsync, sm_vsync, sm_de, sm_le, sm_fs;
  logic [CW-1:0] sm_x, sm_y;
  logic          pol_hsync, pol_vsync, pol_de, pol_le, pol_fs;
  logic [CW-1:0] pol_x, pol_y;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          le;
    logic          fs;
  } exp_t;

  exp_t q_def[$];
  exp_t q_sm[$];
  exp_t q_pol[$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   n_def = 0;
  int   n_sm = 0;
  logic le_def = 1'b0, fs_def = 1'b0, le_sm = 1'b0, fs_sm = 1'b0;

  always #5 clk = ~clk;

  vga_timing_ctrl u_def (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(def_hsync), .vsync(def_vsync), .de(def_de), .x(def_x), .y(def_y),
    .line_end(def_le), .frame_start(def_fs)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(sm_hsync), .vsync(sm_vsync), .de(sm_de), .x(sm_x), .y(sm_y),
    .line_end(sm_le), .frame_start(sm_fs)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) u_pol (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .hsync(pol_hsync), .vsync(pol_vsync), .de(pol_de), .x(pol_x), .y(pol_y),
    .line_end(pol_le), .frame_start(pol_fs)
  );

  // Raster position n (pix_en cycles since reset, modulo frame) decoded by interval.
  function automatic exp_t model_out(input int n, input int ha, input int hf, input int hs,
                                     input int hb, input int va, input int vf, input int vs,
                                     input logic hp, input logic vp, input logic le,
                                     input logic fs);
    exp_t e;
    int   ht;
    int   hpos;
    int   line;
    ht   = ha + hf + hs + hb;
    hpos = n % ht;
    line = n / ht;
    e.de = (hpos < ha) && (line < va);
    e.x  = (hpos < ha) ? CW'(hpos) : '0;
    e.y  = (line < va) ? CW'(line) : '0;
    e.hs = (hpos >= ha + hf && hpos < ha + hf + hs) ? hp : ~hp;
    e.vs = (line >= va + vf && line < va + vf + vs) ? vp : ~vp;
    e.le = le;
    e.fs = fs;
    return e;
  endfunction

  task automatic advance(inout int n, inout logic le, inout logic fs, input int ht,
                         input int ft, input logic r, input logic en);
    if (r) begin
      n  = 0;
      le = 1'b0;
      fs = 1'b0;
    end else if (en) begin
      le = ((n % ht) == ht - 1);
      fs = (n == ft - 1);
      n  = (n + 1) % ft;
    end else begin
      le = 1'b0;
      fs = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic en);
    @(negedge clk);
    rst    = r;
    pix_en = en;
    advance(n_def, le_def, fs_def, 800, 420000, r, en);
    advance(n_sm, le_sm, fs_sm, 8, 48, r, en);
    q_def.push_back(model_out(n_def, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0, le_def, fs_def));
    q_sm.push_back(model_out(n_sm, 4, 1, 2, 1, 3, 1, 1, 1'b0, 1'b0, le_sm, fs_sm));
    q_pol.push_back(model_out(n_sm, 4, 1, 2, 1, 3, 1, 1, 1'b1, 1'b1, le_sm, fs_sm));
  endtask

  task automatic checkValue(input string name, input logic [CW-1:0] act,
                            input logic [CW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input string inst, input exp_t e, input logic hs, input logic vs,
                             input logic d, input logic [CW-1:0] xv, input logic [CW-1:0] yv,
                             input logic le, input logic fs);
    checkValue({inst, ".hsync"}, CW'(hs), CW'(e.hs));
    checkValue({inst, ".vsync"}, CW'(vs), CW'(e.vs));
    checkValue({inst, ".de"}, CW'(d), CW'(e.de));
    checkValue({inst, ".x"}, xv, e.x);
    checkValue({inst, ".y"}, yv, e.y);
    checkValue({inst, ".line_end"}, CW'(le), CW'(e.le));
    checkValue({inst, ".frame_start"}, CW'(fs), CW'(e.fs));
  endtask

  // Monitor: each queued expectation matches the outputs just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q_def.size() > 0) begin
        e = q_def.pop_front();
        checkOutput("def", e, def_hsync, def_vsync, def_de, def_x, def_y, def_le, def_fs);
      end
      if (q_sm.size() > 0) begin
        e = q_sm.pop_front();
        checkOutput("small", e, sm_hsync, sm_vsync, sm_de, sm_x, sm_y, sm_le, sm_fs);
      end
      if (q_pol.size() > 0) begin
        e = q_pol.pop_front();
        checkOutput("pol", e, pol_hsync, pol_vsync, pol_de, pol_x, pol_y, pol_le, pol_fs);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (1700) applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #2;
    // 1700 pixels in: default at line 2 pixel 100; small at line 2, front porch.
    checkValue("def.x@1700", def_x, 10'd100);
    checkValue("def.y@1700", def_y, 10'd2);
    checkValue("def.de@1700", CW'(def_de), 10'd1);
    checkValue("small.x@1700", sm_x, 10'd0);
    checkValue("small.y@1700", sm_y, 10'd2);
    checkValue("small.de@1700", CW'(sm_de), 10'd0);

    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end

    repeat (2) applyStimulus(1'b1, 1'b1);
    repeat (5) applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    #2;
    // Reset landed while the small instances were in their hsync pulse.
    checkValue("small.x@rst", sm_x, 10'd0);
    checkValue("small.y@rst", sm_y, 10'd0);
    checkValue("small.de@rst", CW'(sm_de), 10'd1);
    checkValue("small.hsync@rst", CW'(sm_hsync), 10'd1);
    checkValue("small.vsync@rst", CW'(sm_vsync), 10'd1);
    checkValue("small.frame_start@rst", CW'(sm_fs), 10'd0);
    checkValue("pol.hsync@rst", CW'(pol_hsync), 10'd0);
    checkValue("pol.vsync@rst", CW'(pol_vsync), 10'd0);

    repeat (150) applyStimulus(1'b0, 1'b1);
    repeat (600) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b0, 1'b0);

    @(posedge clk);
    #4;
    n_checks++;
    if (q_def.size() + q_sm.size() + q_pol.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain actual=%0d pending required=0",
               q_def.size() + q_sm.size() + q_pol.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
